// File: rtl/nmr_voter_seq_pkg.sv
// Shared constants and helpers for the NMR voter.
// Counter width, mask encoding and a clog2 helper.
package nmr_voter_seq_pkg;

  localparam int NMR_CNT_W = 4;

  // Fault mask encoding: a set bit means the replica is disabled.
  localparam logic MASK_DIS = 1'b1;

  function automatic int nmr_clog2(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/nmr_voter_seq_if.sv
// Replica input bundle and voted/status outputs.
// The voter uses the slave modport; the driver uses master.
interface nmr_voter_seq_if #(
  parameter int WIDTH = 32,
  parameter int N     = 8
);
  import nmr_voter_seq_pkg::*;

  localparam int AW = nmr_clog2(N + 1);

  logic               in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic               clear_faults;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_tie;
  logic [N-1:0]       out_mismatch;
  logic [N-1:0]       fault_mask;
  logic [AW-1:0]      active_count;
  logic               no_quorum;

  modport master (
    output in_valid, in_data, clear_faults,
    input  out_valid, out_data, out_tie,
    input  out_mismatch, fault_mask,
    input  active_count, no_quorum
  );

  modport slave (
    input  in_valid, in_data, clear_faults,
    output out_valid, out_data, out_tie,
    output out_mismatch, fault_mask,
    output active_count, no_quorum
  );

endinterface

// File: rtl/nmr_bit_vote.sv
// Single-bit majority over the enabled replicas.
// A tie resolves to 0; no tie is flagged with no voters.
module nmr_bit_vote
  import nmr_voter_seq_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = nmr_clog2(N + 1)
) (
  input  logic [N-1:0]  votes,
  input  logic [N-1:0]  mask,
  input  logic [AW-1:0] active_count,
  output logic          vote,
  output logic          tie
);

  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [AW:0]   ones;
  logic [AW+1:0] dbl;
  logic [AW+1:0] act;

  // Count enabled replicas voting 1.
  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++) begin
      if (votes[i] && (mask[i] != MASK_DIS))
        ones = ones + ONE;
    end
  end

  assign dbl  = {ones, 1'b0};
  assign act  = {2'b00, active_count};
  assign vote = dbl > act;
  assign tie  = (dbl == act) && (active_count != '0);

endmodule

// File: rtl/nmr_voter_seq.sv
// Registered N-modular-redundant voter with per-replica
// fault counters, sticky fault mask and mass-disable guard.
module nmr_voter_seq
  import nmr_voter_seq_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int N           = 8,
  parameter int FAULT_LIMIT = 2
) (
  input logic            clk,
  input logic            reset,
  nmr_voter_seq_if.slave bus
);

  localparam int AW = nmr_clog2(N + 1);

  typedef logic [NMR_CNT_W-1:0] cnt_t;

  localparam cnt_t          LIM   = NMR_CNT_W'(FAULT_LIMIT);
  localparam cnt_t          C_ONE = NMR_CNT_W'(1);
  localparam logic [AW-1:0] ACT_N = AW'(N);
  localparam logic [AW-1:0] A_ONE = AW'(1);
  localparam logic [AW-1:0] A_TWO = AW'(2);

  cnt_t          cnt_q [N];
  cnt_t          cnt_d [N];
  logic [N-1:0]  mask_q;
  logic [N-1:0]  mask_d;
  logic [N-1:0]  mask_try;
  logic [N-1:0]  mis;
  logic [AW-1:0] act_q;
  logic [AW-1:0] act_d;
  logic [AW-1:0] act_try;
  logic          nq_q;

  logic [WIDTH-1:0] vote_data;
  logic [WIDTH-1:0] tie_bits;
  logic             tie_any;
  logic             upd;

  logic             ov_q;
  logic [WIDTH-1:0] od_q;
  logic             ot_q;
  logic [N-1:0]     om_q;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [N-1:0] col;

    // Gather bit b of every replica.
    always_comb begin
      col = '0;
      for (int i = 0; i < N; i++)
        col[i] = bus.in_data[i*WIDTH + b];
    end

    nmr_bit_vote #(
      .N (N),
      .AW(AW)
    ) u_vote (
      .votes       (col),
      .mask        (mask_q),
      .active_count(act_q),
      .vote        (vote_data[b]),
      .tie         (tie_bits[b])
    );
  end

  assign tie_any = |tie_bits;
  assign upd = bus.in_valid && !tie_any && !nq_q;

  // Enabled replicas whose word differs from the vote.
  always_comb begin
    mis = '0;
    for (int i = 0; i < N; i++) begin
      mis[i] = (mask_q[i] != MASK_DIS) &&
               (bus.in_data[i*WIDTH +: WIDTH] != vote_data);
    end
    if (nq_q)
      mis = '0;
  end

  // Counter/mask next state, guard and clear priority.
  always_comb begin
    mask_try = mask_q;
    mask_d   = mask_q;
    act_try  = '0;
    act_d    = '0;
    for (int i = 0; i < N; i++)
      cnt_d[i] = cnt_q[i];
    if (upd) begin
      for (int i = 0; i < N; i++) begin
        if (mask_q[i] != MASK_DIS) begin
          if (mis[i]) begin
            if (cnt_q[i] != LIM)
              cnt_d[i] = cnt_q[i] + C_ONE;
            if (cnt_d[i] == LIM)
              mask_try[i] = MASK_DIS;
          end else begin
            cnt_d[i] = '0;
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (mask_try[i] != MASK_DIS)
        act_try = act_try + A_ONE;
    end
    if (act_try >= A_TWO)
      mask_d = mask_try;
    for (int i = 0; i < N; i++) begin
      if (mask_d[i] != MASK_DIS)
        act_d = act_d + A_ONE;
    end
    if (bus.clear_faults) begin
      for (int i = 0; i < N; i++)
        cnt_d[i] = '0;
      mask_d = '0;
      act_d  = ACT_N;
    end
  end

  // Fault state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++)
        cnt_q[i] <= '0;
      mask_q <= '0;
      act_q  <= ACT_N;
      nq_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++)
        cnt_q[i] <= cnt_d[i];
      mask_q <= mask_d;
      act_q  <= act_d;
      nq_q   <= act_d < A_TWO;
    end
  end

  // Vote result registers, valid one cycle after input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ov_q <= 1'b0;
      od_q <= '0;
      ot_q <= 1'b0;
      om_q <= '0;
    end else begin
      ov_q <= bus.in_valid;
      if (bus.in_valid) begin
        od_q <= vote_data;
        ot_q <= tie_any;
        om_q <= mis;
      end else begin
        od_q <= '0;
        ot_q <= 1'b0;
        om_q <= '0;
      end
    end
  end

  assign bus.out_valid    = ov_q;
  assign bus.out_data     = od_q;
  assign bus.out_tie      = ot_q;
  assign bus.out_mismatch = om_q;
  assign bus.fault_mask   = mask_q;
  assign bus.active_count = act_q;
  assign bus.no_quorum    = nq_q;

endmodule

// File: tb/tb_nmr_voter_seq.sv
// Directed bench for nmr_voter_seq: N=8, WIDTH=32,
// FAULT_LIMIT=2, hand-computed expectations.
module tb_nmr_voter_seq;

  localparam int W = 32;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  nmr_voter_seq_if #(.WIDTH(W), .N(N)) bus ();

  nmr_voter_seq #(
    .WIDTH      (W),
    .N          (N),
    .FAULT_LIMIT(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] rep(
    input logic [W-1:0] base,
    input logic [N-1:0] sel,
    input logic [W-1:0] alt
  );
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++)
      r[i*W +: W] = sel[i] ? alt : base;
    return r;
  endfunction

  task automatic drive(input logic [N*W-1:0] d, input logic clr);
    bus.in_valid     = 1'b1;
    bus.in_data      = d;
    bus.clear_faults = clr;
    @(posedge clk);
    #1;
    bus.in_valid     = 1'b0;
    bus.clear_faults = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL rst_data got=%h want=0", bus.out_data); end
    checks++; if (bus.out_tie !== 1'b0) begin errors++; $display("FAIL rst_tie got=%b want=0", bus.out_tie); end
    checks++; if (bus.out_mismatch !== 8'h00) begin errors++; $display("FAIL rst_mis got=%h want=00", bus.out_mismatch); end
    checks++; if (bus.fault_mask !== 8'h00) begin errors++; $display("FAIL rst_mask got=%h want=00", bus.fault_mask); end
    checks++; if (bus.active_count !== 4'd8) begin errors++; $display("FAIL rst_active got=%0d want=8", bus.active_count); end
    checks++; if (bus.no_quorum !== 1'b0) begin errors++; $display("FAIL rst_nq got=%b want=0", bus.no_quorum); end
    reset = 1'b0;
  endtask

  task automatic test_all_equal();
    drive(rep(32'h0000_1234, 8'h00, 32'h0), 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL eq_valid got=%b want=1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0000_1234) begin errors++; $display("FAIL eq_data got=%h want=00001234", bus.out_data); end
    checks++; if (bus.out_mismatch !== 8'h00) begin errors++; $display("FAIL eq_mis got=%h want=00", bus.out_mismatch); end
    checks++; if (bus.active_count !== 4'd8) begin errors++; $display("FAIL eq_active got=%0d want=8", bus.active_count); end
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL eq_idle got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_disable();
    drive(rep(32'h0000_00AA, 8'h08, 32'hFFFF_FFFF), 1'b0);
    checks++; if (bus.out_data !== 32'h0000_00AA) begin errors++; $display("FAIL dis1_data got=%h want=000000aa", bus.out_data); end
    checks++; if (bus.out_mismatch !== 8'h08) begin errors++; $display("FAIL dis1_mis got=%h want=08", bus.out_mismatch); end
    checks++; if (bus.fault_mask !== 8'h00) begin errors++; $display("FAIL dis1_mask got=%h want=00", bus.fault_mask); end
    drive(rep(32'h0000_00AA, 8'h08, 32'hFFFF_FFFF), 1'b0);
    checks++; if (bus.out_data !== 32'h0000_00AA) begin errors++; $display("FAIL dis2_data got=%h want=000000aa", bus.out_data); end
    checks++; if (bus.out_mismatch !== 8'h08) begin errors++; $display("FAIL dis2_mis got=%h want=08", bus.out_mismatch); end
    checks++; if (bus.fault_mask !== 8'h08) begin errors++; $display("FAIL dis2_mask got=%h want=08", bus.fault_mask); end
    checks++; if (bus.active_count !== 4'd7) begin errors++; $display("FAIL dis2_active got=%0d want=7", bus.active_count); end
    drive(rep(32'h0000_00AA, 8'h08, 32'hFFFF_FFFF), 1'b0);
    checks++; if (bus.out_data !== 32'h0000_00AA) begin errors++; $display("FAIL dis3_data got=%h want=000000aa", bus.out_data); end
    checks++; if (bus.out_mismatch !== 8'h00) begin errors++; $display("FAIL dis3_mis got=%h want=00", bus.out_mismatch); end
  endtask

  task automatic test_minority();
    drive(rep(32'h0, 8'h07, 32'h1), 1'b0);
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL min_data got=%h want=0", bus.out_data); end
    checks++; if (bus.out_mismatch !== 8'h07) begin errors++; $display("FAIL min_mis got=%h want=07", bus.out_mismatch); end
    checks++; if (bus.fault_mask !== 8'h08) begin errors++; $display("FAIL min_mask got=%h want=08", bus.fault_mask); end
    checks++; if (bus.active_count !== 4'd7) begin errors++; $display("FAIL min_active got=%0d want=7", bus.active_count); end
  endtask

  task automatic test_clear_priority();
    drive(rep(32'h0, 8'h0F, 32'h1), 1'b1);
    checks++; if (bus.out_tie !== 1'b0) begin errors++; $display("FAIL clr_tie got=%b want=0", bus.out_tie); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL clr_data got=%h want=0", bus.out_data); end
    checks++; if (bus.out_mismatch !== 8'h07) begin errors++; $display("FAIL clr_mis got=%h want=07", bus.out_mismatch); end
    checks++; if (bus.fault_mask !== 8'h00) begin errors++; $display("FAIL clr_mask got=%h want=00", bus.fault_mask); end
    checks++; if (bus.active_count !== 4'd8) begin errors++; $display("FAIL clr_active got=%0d want=8", bus.active_count); end
    drive(rep(32'h0, 8'h01, 32'h1), 1'b0);
    checks++; if (bus.out_mismatch !== 8'h01) begin errors++; $display("FAIL clr_post_mis got=%h want=01", bus.out_mismatch); end
    checks++; if (bus.fault_mask !== 8'h00) begin errors++; $display("FAIL clr_post_mask got=%h want=00", bus.fault_mask); end
  endtask

  task automatic test_counter_reset();
    drive(rep(32'h55, 8'h20, 32'h11), 1'b0);
    checks++; if (bus.out_mismatch !== 8'h20) begin errors++; $display("FAIL cr1_mis got=%h want=20", bus.out_mismatch); end
    drive(rep(32'h55, 8'h00, 32'h11), 1'b0);
    checks++; if (bus.out_mismatch !== 8'h00) begin errors++; $display("FAIL cr2_mis got=%h want=00", bus.out_mismatch); end
    drive(rep(32'h55, 8'h20, 32'h11), 1'b0);
    checks++; if (bus.out_data !== 32'h55) begin errors++; $display("FAIL cr3_data got=%h want=55", bus.out_data); end
    checks++; if (bus.out_mismatch !== 8'h20) begin errors++; $display("FAIL cr3_mis got=%h want=20", bus.out_mismatch); end
    checks++; if (bus.fault_mask !== 8'h00) begin errors++; $display("FAIL cr3_mask got=%h want=00", bus.fault_mask); end
  endtask

  task automatic test_tie();
    drive(rep(32'h0, 8'h0F, 32'h1), 1'b0);
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL tie_data got=%h want=0", bus.out_data); end
    checks++; if (bus.out_tie !== 1'b1) begin errors++; $display("FAIL tie_flag got=%b want=1", bus.out_tie); end
    checks++; if (bus.out_mismatch !== 8'h0F) begin errors++; $display("FAIL tie_mis got=%h want=0f", bus.out_mismatch); end
    checks++; if (bus.fault_mask !== 8'h00) begin errors++; $display("FAIL tie_mask got=%h want=00", bus.fault_mask); end
    drive(rep(32'h55, 8'h20, 32'h11), 1'b0);
    checks++; if (bus.out_tie !== 1'b0) begin errors++; $display("FAIL tie_after_flag got=%b want=0", bus.out_tie); end
    checks++; if (bus.fault_mask !== 8'h20) begin errors++; $display("FAIL tie_after_mask got=%h want=20", bus.fault_mask); end
    checks++; if (bus.active_count !== 4'd7) begin errors++; $display("FAIL tie_after_active got=%0d want=7", bus.active_count); end
    bus.clear_faults = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_faults = 1'b0;
    checks++; if (bus.fault_mask !== 8'h00) begin errors++; $display("FAIL clr_only_mask got=%h want=00", bus.fault_mask); end
    checks++; if (bus.active_count !== 4'd8) begin errors++; $display("FAIL clr_only_active got=%0d want=8", bus.active_count); end
  endtask

  task automatic test_guard();
    logic [N*W-1:0] d;
    drive(rep(32'h0, 8'h07, 32'h1), 1'b0);
    drive(rep(32'h0, 8'h07, 32'h1), 1'b0);
    checks++; if (bus.fault_mask !== 8'h07) begin errors++; $display("FAIL g1_mask got=%h want=07", bus.fault_mask); end
    checks++; if (bus.active_count !== 4'd5) begin errors++; $display("FAIL g1_active got=%0d want=5", bus.active_count); end
    drive(rep(32'h0, 8'h18, 32'h1), 1'b0);
    checks++; if (bus.out_mismatch !== 8'h18) begin errors++; $display("FAIL g2_mis got=%h want=18", bus.out_mismatch); end
    drive(rep(32'h0, 8'h18, 32'h1), 1'b0);
    checks++; if (bus.fault_mask !== 8'h1F) begin errors++; $display("FAIL g2_mask got=%h want=1f", bus.fault_mask); end
    checks++; if (bus.active_count !== 4'd3) begin errors++; $display("FAIL g2_active got=%0d want=3", bus.active_count); end
    d = rep(32'h0, 8'h20, 32'h1);
    d[6*W +: W] = 32'h2;
    drive(d, 1'b0);
    checks++; if (bus.out_mismatch !== 8'h60) begin errors++; $display("FAIL g3_mis got=%h want=60", bus.out_mismatch); end
    drive(d, 1'b0);
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL g4_data got=%h want=0", bus.out_data); end
    checks++; if (bus.out_mismatch !== 8'h60) begin errors++; $display("FAIL g4_mis got=%h want=60", bus.out_mismatch); end
    checks++; if (bus.fault_mask !== 8'h1F) begin errors++; $display("FAIL g4_mask got=%h want=1f", bus.fault_mask); end
    checks++; if (bus.active_count !== 4'd3) begin errors++; $display("FAIL g4_active got=%0d want=3", bus.active_count); end
    checks++; if (bus.no_quorum !== 1'b0) begin errors++; $display("FAIL g4_nq got=%b want=0", bus.no_quorum); end
    drive(rep(32'h0, 8'h20, 32'h1), 1'b0);
    checks++; if (bus.fault_mask !== 8'h3F) begin errors++; $display("FAIL g5_mask got=%h want=3f", bus.fault_mask); end
    checks++; if (bus.active_count !== 4'd2) begin errors++; $display("FAIL g5_active got=%0d want=2", bus.active_count); end
    drive(rep(32'h0, 8'h40, 32'h1), 1'b0);
    checks++; if (bus.out_tie !== 1'b1) begin errors++; $display("FAIL g6_tie got=%b want=1", bus.out_tie); end
    checks++; if (bus.fault_mask !== 8'h3F) begin errors++; $display("FAIL g6_mask got=%h want=3f", bus.fault_mask); end
    checks++; if (bus.no_quorum !== 1'b0) begin errors++; $display("FAIL g6_nq got=%b want=0", bus.no_quorum); end
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1;
    bus.in_data  = rep(32'h0000_1234, 8'h00, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.out_tie !== 1'b0) begin errors++; $display("FAIL rm_tie got=%b want=0", bus.out_tie); end
    checks++; if (bus.fault_mask !== 8'h00) begin errors++; $display("FAIL rm_mask got=%h want=00", bus.fault_mask); end
    checks++; if (bus.active_count !== 4'd8) begin errors++; $display("FAIL rm_active got=%0d want=8", bus.active_count); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_after got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    drive(rep(32'h0000_1234, 8'h00, 32'h0), 1'b0);
    checks++; if (bus.out_data !== 32'h0000_1234) begin errors++; $display("FAIL b2b1_data got=%h want=00001234", bus.out_data); end
    drive(rep(32'hCAFE_BABE, 8'h00, 32'h0), 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b2_valid got=%b want=1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'hCAFE_BABE) begin errors++; $display("FAIL b2b2_data got=%h want=cafebabe", bus.out_data); end
    drive(rep(32'h0000_00A5, 8'h80, 32'h0000_005A), 1'b0);
    checks++; if (bus.out_data !== 32'h0000_00A5) begin errors++; $display("FAIL b2b3_data got=%h want=000000a5", bus.out_data); end
    checks++; if (bus.out_mismatch !== 8'h80) begin errors++; $display("FAIL b2b3_mis got=%h want=80", bus.out_mismatch); end
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b want=0", bus.out_valid); end
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.clear_faults = 1'b0;
    reset            = 1'b1;
    test_reset();
    test_all_equal();
    test_disable();
    test_minority();
    test_clear_priority();
    test_counter_reset();
    test_tie();
    test_guard();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
